// File: rtl/usb_rx_ctrl_pkg.sv
// Shared types and constants for the USB low-speed receive path.
// Line symbols are encoded as {D+, D-}.
package usb_rx_ctrl_pkg;

    // Low-speed signalling: J is D- high, K is D+ high.
    typedef enum logic [1:0] {
        SE0 = 2'b00,
        J   = 2'b01,
        K   = 2'b10,
        SE1 = 2'b11
    } d_port_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        DATA  = 3'd2,
        EOP   = 3'd3,
        ABORT = 3'd4
    } rx_state_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_SYNC    = 3'd1,
        ERR_STUFF   = 3'd2,
        ERR_BABBLE  = 3'd3,
        ERR_DRIBBLE = 3'd4,
        ERR_EOP     = 3'd5
    } rx_err_t;

    // Decoded zeros in KJKJKJK before the closing K.
    localparam logic [2:0] SYNC_ZEROS = 3'd6;

    function automatic logic is_jk(d_port_t s);
        return (s == J) || (s == K);
    endfunction

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder and bit-unstuffing counter for the USB receive path.
// Flags data bits, stuff bits and stuff violations per CDR strobe.
module usb_nrzi_unstuff
    import usb_rx_ctrl_pkg::*;
#(
    parameter int unsigned STUFF_LEN = 6
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    strobe,
    input  d_port_t cdr_q,
    input  logic    unstuff_en,
    input  logic    ones_clr,
    input  logic    prev_set_j,
    output logic    dec_bit,
    output logic    sym_jk,
    output logic    data_valid,
    output logic    stuff_err
);
    localparam logic [2:0] STUFF_MAX = 3'(STUFF_LEN);

    d_port_t    prev_q;
    logic [2:0] ones_cnt_q;
    logic       at_stuff;
    logic       bit_strobe;

    assign sym_jk     = is_jk(cdr_q);
    assign dec_bit    = (cdr_q == prev_q);
    assign at_stuff   = (ones_cnt_q == STUFF_MAX);
    assign bit_strobe = strobe && sym_jk && unstuff_en;
    assign data_valid = bit_strobe && !at_stuff;
    assign stuff_err  = bit_strobe && at_stuff && dec_bit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= J;
            ones_cnt_q <= '0;
        end else begin
            if (prev_set_j) begin
                prev_q <= J;
            end else if (strobe && sym_jk) begin
                prev_q <= cdr_q;
            end

            if (ones_clr) begin
                ones_cnt_q <= '0;
            end else if (bit_strobe) begin
                // A stuffed zero is dropped and restarts the run.
                if (at_stuff || !dec_bit) begin
                    ones_cnt_q <= '0;
                end else begin
                    ones_cnt_q <= ones_cnt_q + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/usb_rx_ctrl.sv
// Receive-side packet controller: SYNC, NRZI/unstuff, byte assembly, EOP, errors.
// Optional error counter (err_clr / err_count) is built when USB_RX_ERRCNT_EN is defined.
module usb_rx_ctrl
    import usb_rx_ctrl_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 11,
    parameter int unsigned STUFF_LEN = 6,
    parameter int unsigned IDLE_BITS = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  d_port_t    cdr_q,
    input  logic       cdr_strobe,
    input  d_port_t    line_state,
`ifdef USB_RX_ERRCNT_EN
    input  logic       err_clr,
    output logic [7:0] err_count,
`endif
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       rx_eop,
    output logic       rx_error,
    output logic [2:0] err_code
);
    localparam int unsigned BYTE_W = $clog2(MAX_BYTES + 2);
    localparam int unsigned IDLE_W = $clog2(IDLE_BITS + 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(MAX_BYTES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_BITS - 1);

    rx_state_t         state_q, state_d;
    logic [2:0]        sync_cnt_q, sync_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              eop_se0_q, eop_se0_d;
    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

    logic [7:0]        rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_active_q, rx_active_d;
    logic              rx_eop_q, rx_eop_d;
    logic              rx_error_q, rx_error_d;
    rx_err_t           err_code_q, err_code_d;

    logic              dec_bit;
    logic              sym_jk;
    logic              data_valid;
    logic              stuff_err;
    logic              ones_clr;
    logic              prev_set_j;
    logic              unstuff_en;

    logic              go_abort;
    rx_err_t           abort_code;

    assign unstuff_en = (state_q == DATA);

    usb_nrzi_unstuff #(
        .STUFF_LEN (STUFF_LEN)
    ) u_nrzi_unstuff (
        .clk        (clk),
        .reset_n    (reset_n),
        .strobe     (cdr_strobe),
        .cdr_q      (cdr_q),
        .unstuff_en (unstuff_en),
        .ones_clr   (ones_clr),
        .prev_set_j (prev_set_j),
        .dec_bit    (dec_bit),
        .sym_jk     (sym_jk),
        .data_valid (data_valid),
        .stuff_err  (stuff_err)
    );

    always_comb begin
        state_d     = state_q;
        sync_cnt_d  = sync_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        shreg_d     = shreg_q;
        eop_se0_d   = eop_se0_q;
        idle_cnt_d  = idle_cnt_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        rx_active_d = rx_active_q;
        rx_eop_d    = 1'b0;
        rx_error_d  = 1'b0;
        err_code_d  = err_code_q;
        ones_clr    = 1'b0;
        prev_set_j  = 1'b0;
        go_abort    = 1'b0;
        abort_code  = ERR_NONE;

        if (cdr_strobe) begin
            unique case (state_q)
                IDLE: begin
                    if (cdr_q == K && line_state != J) begin
                        state_d    = SYNC;
                        sync_cnt_d = '0;
                    end
                end

                SYNC: begin
                    if (!sym_jk) begin
                        go_abort   = 1'b1;
                        abort_code = ERR_SYNC;
                    end else if (!dec_bit) begin
                        if (sync_cnt_q == SYNC_ZEROS) begin
                            go_abort   = 1'b1;
                            abort_code = ERR_SYNC;
                        end else begin
                            sync_cnt_d = sync_cnt_q + 3'd1;
                        end
                    end else if (sync_cnt_q == SYNC_ZEROS) begin
                        state_d     = DATA;
                        rx_active_d = 1'b1;
                        bit_cnt_d   = '0;
                        byte_cnt_d  = '0;
                        ones_clr    = 1'b1;
                    end else begin
                        go_abort   = 1'b1;
                        abort_code = ERR_SYNC;
                    end
                end

                DATA: begin
                    if (cdr_q == SE0) begin
                        state_d   = EOP;
                        eop_se0_d = 1'b0;
                    end else if (cdr_q == SE1) begin
                        go_abort   = 1'b1;
                        abort_code = ERR_EOP;
                    end else if (stuff_err) begin
                        go_abort   = 1'b1;
                        abort_code = ERR_STUFF;
                    end else if (data_valid) begin
                        shreg_d   = {dec_bit, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                            // The byte that would exceed MAX_BYTES is never delivered.
                            if (byte_cnt_q == BYTE_LAST) begin
                                go_abort   = 1'b1;
                                abort_code = ERR_BABBLE;
                            end else begin
                                rx_valid_d = 1'b1;
                                rx_data_d  = shreg_d;
                            end
                        end
                    end
                end

                EOP: begin
                    if (cdr_q == SE0) begin
                        if (eop_se0_q) begin
                            go_abort   = 1'b1;
                            abort_code = ERR_EOP;
                        end else begin
                            eop_se0_d = 1'b1;
                        end
                    end else if (cdr_q == J && eop_se0_q) begin
                        if (bit_cnt_q == 3'd0) begin
                            rx_eop_d = 1'b1;
                        end else begin
                            rx_error_d = 1'b1;
                            err_code_d = ERR_DRIBBLE;
                        end
                        rx_active_d = 1'b0;
                        prev_set_j  = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        go_abort   = 1'b1;
                        abort_code = ERR_EOP;
                    end
                end

                ABORT: begin
                    // Any non-J symbol breaks the run of idle strobes.
                    if (cdr_q == J) begin
                        if (idle_cnt_q == IDLE_LAST) begin
                            state_d    = IDLE;
                            prev_set_j = 1'b1;
                        end else begin
                            idle_cnt_d = idle_cnt_q + 1'b1;
                        end
                    end else begin
                        idle_cnt_d = '0;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (go_abort) begin
            state_d     = ABORT;
            rx_error_d  = 1'b1;
            err_code_d  = abort_code;
            rx_active_d = 1'b0;
            rx_valid_d  = 1'b0;
            idle_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            sync_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            shreg_q     <= '0;
            eop_se0_q   <= 1'b0;
            idle_cnt_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_active_q <= 1'b0;
            rx_eop_q    <= 1'b0;
            rx_error_q  <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            sync_cnt_q  <= sync_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            shreg_q     <= shreg_d;
            eop_se0_q   <= eop_se0_d;
            idle_cnt_q  <= idle_cnt_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_active_q <= rx_active_d;
            rx_eop_q    <= rx_eop_d;
            rx_error_q  <= rx_error_d;
            err_code_q  <= err_code_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign rx_active = rx_active_q;
    assign rx_eop    = rx_eop_q;
    assign rx_error  = rx_error_q;
    assign err_code  = err_code_q;

`ifdef USB_RX_ERRCNT_EN
    logic [7:0] err_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q <= '0;
        end else if (err_clr) begin
            err_count_q <= '0;
        end else if (rx_error_q && err_count_q != 8'hff) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Packet-level randomized bench for usb_rx_ctrl: packets are built as line symbols
// from byte payloads, and expected bytes/events come from the packet description.
module tb_usb_rx_ctrl;
    import usb_rx_ctrl_pkg::*;

    localparam int unsigned MAX_BYTES = 11;
    localparam int unsigned STUFF_LEN = 6;
    localparam int unsigned IDLE_BITS = 7;

    localparam int PK_GOOD    = 0;
    localparam int PK_DRIBBLE = 1;
    localparam int PK_STUFF   = 2;
    localparam int PK_BABBLE  = 3;
    localparam int PK_SE1     = 4;
    localparam int PK_BADEOP  = 5;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cdr_strobe = 1'b0;
    d_port_t    cdr_q = J;
    d_port_t    line_state = J;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_active;
    logic       rx_eop;
    logic       rx_error;
    logic [2:0] err_code;
`ifdef USB_RX_ERRCNT_EN
    logic       err_clr = 1'b0;
    logic [7:0] err_count;
    int         exp_errcnt = 0;
`endif

    int         checks = 0;
    int         errors = 0;
    d_port_t    sym_q[$];
    logic [7:0] pay_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int         obs_eop;
    int         obs_err;
    logic [2:0] obs_code;
    int         exp_code = 0;
    d_port_t    level;
    int         ones;

    usb_rx_ctrl #(
        .MAX_BYTES (MAX_BYTES),
        .STUFF_LEN (STUFF_LEN),
        .IDLE_BITS (IDLE_BITS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cdr_q      (cdr_q),
        .cdr_strobe (cdr_strobe),
        .line_state (line_state),
`ifdef USB_RX_ERRCNT_EN
        .err_clr    (err_clr),
        .err_count  (err_count),
`endif
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_active  (rx_active),
        .rx_eop     (rx_eop),
        .rx_error   (rx_error),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_valid) begin
                obs_q.push_back(rx_data);
                check_eq("active_at_valid", 32'(rx_active), 32'd1);
            end
            if (rx_eop) begin
                obs_eop++;
                check_eq("active_at_eop", 32'(rx_active), 32'd0);
            end
            if (rx_error) begin
                obs_err++;
                obs_code = err_code;
            end
        end
    end

    function automatic d_port_t flip(input d_port_t s);
        return (s == J) ? K : J;
    endfunction

    task automatic send_sym(input d_port_t s);
        @(posedge clk);
        #1;
        cdr_q      = s;
        line_state = s;
        cdr_strobe = 1'b1;
        @(posedge clk);
        #1;
        cdr_strobe = 1'b0;
        repeat ($urandom_range(3, 0)) @(posedge clk);
    endtask

    task automatic send_all();
        while (sym_q.size() > 0) send_sym(sym_q.pop_front());
    endtask

    // Data bit -> line symbol with NRZI and a stuffed zero after every run of six ones.
    task automatic push_bit(input logic b);
        if (!b) level = flip(level);
        sym_q.push_back(level);
        if (b) ones++;
        else ones = 0;
        if (ones == int'(STUFF_LEN)) begin
            level = flip(level);
            sym_q.push_back(level);
            ones = 0;
        end
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) push_bit(v[i]);
    endtask

    task automatic push_sync_good();
        d_port_t s[8];
        s = '{K, J, K, J, K, J, K, K};
        for (int i = 0; i < 8; i++) sym_q.push_back(s[i]);
        level = K;
        ones  = 0;
    endtask

    task automatic push_eop();
        sym_q.push_back(SE0);
        sym_q.push_back(SE0);
        sym_q.push_back(J);
    endtask

    task automatic begin_case();
        sym_q.delete();
        exp_q.delete();
        obs_q.delete();
        obs_eop  = 0;
        obs_err  = 0;
        obs_code = '0;
    endtask

    task automatic end_case(input string tag, input int code, input int eop);
        for (int i = 0; i <= int'(IDLE_BITS); i++) sym_q.push_back(J);
        send_all();
        check_eq({tag, ".nbytes"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) check_eq($sformatf("%s.byte%0d", tag, i), obs_q[i], exp_q[i]);
        end
        check_eq({tag, ".eop"}, obs_eop, eop);
        check_eq({tag, ".err_pulses"}, obs_err, (code != 0) ? 1 : 0);
        if (code != 0) begin
            check_eq({tag, ".code_at_pulse"}, 32'(obs_code), code);
            exp_code = code;
`ifdef USB_RX_ERRCNT_EN
            exp_errcnt++;
`endif
        end
        check_eq({tag, ".err_code"}, 32'(err_code), exp_code);
        check_eq({tag, ".active_end"}, 32'(rx_active), 32'd0);
`ifdef USB_RX_ERRCNT_EN
        check_eq({tag, ".err_count"}, 32'(err_count), (exp_errcnt > 255) ? 255 : exp_errcnt);
`endif
    endtask

    task automatic run_pkt(input string tag, input int kind, input int extra);
        int code;
        int eop;
        begin_case();
        push_sync_good();
        send_all();
        check_eq({tag, ".active_sync"}, 32'(rx_active), 32'd1);
        code = 0;
        eop  = 0;
        foreach (pay_q[i]) begin
            push_byte(pay_q[i]);
            if (i < int'(MAX_BYTES)) exp_q.push_back(pay_q[i]);
        end
        case (kind)
            PK_GOOD: begin
                push_eop();
                eop = 1;
            end
            PK_DRIBBLE: begin
                for (int i = 0; i < extra; i++) push_bit(1'($urandom_range(1, 0)));
                push_eop();
                code = 4;
            end
            PK_STUFF: begin
                push_bit(1'b0);
                repeat (7) sym_q.push_back(level);
                code = 2;
            end
            PK_BABBLE: begin
                push_eop();
                code = 3;
            end
            PK_SE1: begin
                sym_q.push_back(SE1);
                code = 5;
            end
            default: begin
                sym_q.push_back(SE0);
                case (extra % 4)
                    0: sym_q.push_back(K);
                    1: sym_q.push_back(SE1);
                    2: begin
                        sym_q.push_back(SE0);
                        sym_q.push_back(SE0);
                    end
                    default: begin
                        sym_q.push_back(SE0);
                        sym_q.push_back(K);
                    end
                endcase
                code = 5;
            end
        endcase
        end_case(tag, code, eop);
    endtask

    // pos 1..6: a decoded one arrives early; pos 7: an eighth alternating symbol.
    task automatic run_bad_sync(input string tag, input int pos);
        d_port_t s[8];
        s = '{K, J, K, J, K, J, K, J};
        begin_case();
        if (pos <= 6) begin
            for (int i = 0; i < pos; i++) sym_q.push_back(s[i]);
            sym_q.push_back(s[pos-1]);
        end else begin
            for (int i = 0; i < 8; i++) sym_q.push_back(s[i]);
        end
        send_all();
        check_eq({tag, ".active_sync"}, 32'(rx_active), 32'd0);
        end_case(tag, 1, 0);
    endtask

    task automatic fill_random(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
    endtask

    initial begin
        #23;
        check_eq("rst.valid", 32'(rx_valid), 32'd0);
        check_eq("rst.active", 32'(rx_active), 32'd0);
        check_eq("rst.eop", 32'(rx_eop), 32'd0);
        check_eq("rst.error", 32'(rx_error), 32'd0);
        check_eq("rst.data", 32'(rx_data), 32'd0);
        check_eq("rst.code", 32'(err_code), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) send_sym(J);

        pay_q = '{8'hC3};
        run_pkt("c3", PK_GOOD, 0);
        pay_q = '{8'hFF, 8'h00};
        run_pkt("ff00", PK_GOOD, 0);
        pay_q = '{8'hA5};
        run_pkt("stuff7", PK_STUFF, 0);
        run_bad_sync("short_sync", 5);
        pay_q = '{8'h2D, 8'h7E};
        run_pkt("after_bad", PK_GOOD, 0);
        fill_random(12);
        run_pkt("babble", PK_BABBLE, 0);
        pay_q.delete();
        run_pkt("dribble5", PK_DRIBBLE, 5);

        // Reset in the middle of a byte must clear everything without an error pulse.
        begin_case();
        push_sync_good();
        send_all();
        check_eq("midrst.active_before", 32'(rx_active), 32'd1);
        push_bit(1'b1);
        push_bit(1'b0);
        push_bit(1'b1);
        send_all();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("midrst.active", 32'(rx_active), 32'd0);
        check_eq("midrst.valid", 32'(rx_valid), 32'd0);
        check_eq("midrst.error", 32'(rx_error), 32'd0);
        check_eq("midrst.code", 32'(err_code), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n  = 1'b1;
        exp_code = 0;
`ifdef USB_RX_ERRCNT_EN
        exp_errcnt = 0;
`endif
        repeat (3) send_sym(J);
        check_eq("midrst.err_pulses", obs_err, 0);
        check_eq("midrst.eop_pulses", obs_eop, 0);
        pay_q = '{8'h69, 8'h12, 8'hFC};
        run_pkt("post_rst", PK_GOOD, 0);

        for (int it = 0; it < 30; it++) begin
            int kind;
            kind = $urandom_range(6, 0);
            case (kind)
                PK_GOOD:    begin fill_random($urandom_range(11, 1)); run_pkt($sformatf("r%0d.good", it), PK_GOOD, 0); end
                PK_DRIBBLE: begin fill_random($urandom_range(11, 0)); run_pkt($sformatf("r%0d.dribble", it), PK_DRIBBLE, $urandom_range(7, 1)); end
                PK_STUFF:   begin fill_random($urandom_range(5, 0)); run_pkt($sformatf("r%0d.stuff", it), PK_STUFF, 0); end
                PK_BABBLE:  begin fill_random(12); run_pkt($sformatf("r%0d.babble", it), PK_BABBLE, 0); end
                PK_SE1:     begin fill_random($urandom_range(6, 0)); run_pkt($sformatf("r%0d.se1", it), PK_SE1, 0); end
                PK_BADEOP:  begin fill_random($urandom_range(6, 0)); run_pkt($sformatf("r%0d.badeop", it), PK_BADEOP, $urandom_range(3, 0)); end
                default:    run_bad_sync($sformatf("r%0d.badsync", it), $urandom_range(7, 1));
            endcase
        end

`ifdef USB_RX_ERRCNT_EN
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr    = 1'b0;
        exp_errcnt = 0;
        check_eq("err_clr", 32'(err_count), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_rx_ctrl.md
Name: usb_rx_ctrl

Overview:
- Receive-side packet controller for the USB low-speed (1.5 Mb/s) path; sits directly downstream of the oversampled CDR.
- Consumes the retimed D+/D- pair and the per-bit data strobe from the CDR.
- Sequences a packet through SYNC detection, NRZI decoding, bit unstuffing, byte assembly and EOP detection.
- Delivers bytes plus packet framing and error status to the protocol engine.

Parameters:
- MAX_BYTES, 11, maximum bytes per packet (PID + 8 data + CRC16); one more byte is a babble error.
- STUFF_LEN, 6, number of consecutive decoded ones after which one stuffed zero follows.
- IDLE_BITS, 7, consecutive J strobes needed in ABORT before returning to IDLE.

Ports:
- clk  in  1  system clock (24 MHz)
- reset_n  in  1  asynchronous active-low reset
- cdr_q  in  d_port_t  retimed D+/D- from CDR
- cdr_strobe  in  1  one-clk bit strobe from CDR; all bit processing happens only on cycles where it is high
- line_state  in  d_port_t  synchronized raw line state, used only in IDLE
- rx_data  out  8  assembled byte, LSB received first
- rx_valid  out  1  one-clk pulse; rx_data valid
- rx_active  out  1  high from SYNC accept until packet end or error
- rx_eop  out  1  one-clk pulse on clean EOP
- rx_error  out  1  one-clk pulse on any error
- err_code  out  3  cause, held until the next error: 0 none, 1 bad SYNC, 2 stuff error, 3 babble, 4 dribble (partial byte at EOP), 5 SE1/bad EOP

Behaviour:
- Clock and reset:
  - Single clock; reset is asynchronous, active-low.
  - All registers clear on reset: outputs 0, err_code 0, state IDLE, prev_q = J.
  - Reset mid-packet aborts silently; no rx_error or rx_eop is generated.
- NRZI decoding (on each strobe with cdr_q ∈ {J,K}):
  - Decoded bit = 1 if cdr_q == prev_q, else 0.
  - prev_q <= cdr_q.
- IDLE:
  - On a strobe with cdr_q == K (and line_state != J), go to SYNC with sync_cnt = 0.
  - SE0 in IDLE is ignored.
- SYNC (expected pattern KJKJKJKK):
  - Each strobe decoding 0: sync_cnt++.
  - Decoded 1 with sync_cnt == 6: go to DATA, rx_active <= 1, clear bit_cnt, byte_cnt and ones_cnt.
  - Decoded 1 with any other sync_cnt, or sync_cnt reaching 7: err_code 1, go to ABORT.
  - SE0/SE1 during SYNC: err_code 1, ABORT.
- DATA:
  - If ones_cnt == STUFF_LEN:
    - Decoded 0: stuff bit, discarded, ones_cnt = 0.
    - Decoded 1: err_code 2, ABORT.
  - Otherwise: shift the bit into the byte register (LSB first) and bit_cnt++. ones_cnt++ on a 1, cleared on a 0.
  - When bit_cnt wraps 7→0:
    - rx_data/rx_valid are driven on the clk after that strobe (latency 1 clk).
    - byte_cnt++.
    - If byte_cnt would exceed MAX_BYTES: err_code 3, ABORT, and no rx_valid for that byte.
  - SE0 strobe: go to EOP.
  - SE1 strobe: err_code 5, ABORT.
- EOP:
  - Requires exactly 2 SE0 strobes followed by a J strobe.
  - On the J strobe:
    - bit_cnt == 0: rx_eop pulse.
    - bit_cnt != 0: err_code 4 and rx_error pulse.
    - Either way: rx_active <= 0, prev_q = J, go to IDLE.
  - K, SE1, or a third SE0: err_code 5, ABORT.
- ABORT:
  - rx_error pulses on entry, rx_active <= 0.
  - Stay until IDLE_BITS consecutive J strobes (SE0 resets the count), then go to IDLE with prev_q = J.
- Simultaneous events:
  - A byte completing on the same strobe as a stuff error cannot occur (stuff bits are not data).
  - A babble check and byte completion on the same strobe: the error wins.
- Counter widths:
  - byte_cnt: $clog2(MAX_BYTES+2) bits.
  - sync_cnt, ones_cnt, bit_cnt: 3 bits.

Optional Feature:
- Macro USB_RX_ERRCNT_EN.
- When defined:
  - Adds output err_count [7:0], cleared on reset.
  - Increments once per rx_error pulse and saturates at 255.
  - Adds input err_clr, a synchronous clear; err_clr wins over a simultaneous increment.
- When undefined: neither port exists and there is no counter logic.

Decomposition:
- Shared package types (already holds d_port_t with J/K/SE0/SE1) gains:
  - rx_state_t enum {IDLE, SYNC, DATA, EOP, ABORT}
  - rx_err_t enum for err_code values
  - constant SYNC_ZEROS = 6
- One natural sub-module, usb_nrzi_unstuff: NRZI decode plus the stuff counter. It outputs bit/bit_valid/stuff_err per strobe; the FSM instantiates it.

Test Plan:
- Idle J, then SYNC KJKJKJKK, byte 0xC3 (PID DATA0), SE0 SE0 J -> one rx_valid with rx_data = 0xC3, then rx_eop; rx_active high for exactly that span; err_code 0.
- Byte 0xFF followed by 0x00 -> stuffed 0 after 6 ones removed; rx_data sequence 0xFF, 0x00; no error.
- Seven identical consecutive line states (7 decoded ones) inside DATA -> rx_error, err_code 2, rx_active falls, no rx_valid for the partial byte; 7 J strobes later, back in IDLE.
- SYNC KJKJKK (short) -> rx_error, err_code 1; a following valid packet is accepted normally.
- 12 bytes before EOP -> 11 rx_valid pulses, then rx_error, err_code 3; 5 bits then EOP -> err_code 4.
- Assert reset_n low mid-byte -> all outputs 0 asynchronously, no rx_error; next packet decoded correctly. With USB_RX_ERRCNT_EN: 3 errors -> err_count = 3; err_clr -> 0.
